// File: rtl/id_stage_if.sv
// id_stage_if: IF/ID inputs, write-back port and ID/EX outputs of the decode stage.
interface id_stage_if;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instruction;
   logic        if_id_valid;
   logic        flush;
   logic        hold;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        stall;
   logic [31:0] id_ex_pc;
   logic [31:0] id_ex_rs1_data;
   logic [31:0] id_ex_rs2_data;
   logic [31:0] id_ex_imm;
   logic [4:0]  id_ex_rs1;
   logic [4:0]  id_ex_rs2;
   logic [4:0]  id_ex_rd;
   logic [2:0]  id_ex_funct3;
   logic [3:0]  id_ex_alu_op;
   logic [8:0]  id_ex_ctrl;
   logic        id_ex_valid;
   logic        id_ex_illegal;
   modport master (
      output if_id_pc, if_id_instruction, if_id_valid, flush, hold, wb_we, wb_rd, wb_data,
      input  stall, id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm, id_ex_rs1, id_ex_rs2,
             id_ex_rd, id_ex_funct3, id_ex_alu_op, id_ex_ctrl, id_ex_valid, id_ex_illegal
   );
   modport slave (
      input  if_id_pc, if_id_instruction, if_id_valid, flush, hold, wb_we, wb_rd, wb_data,
      output stall, id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm, id_ex_rs1, id_ex_rs2,
             id_ex_rd, id_ex_funct3, id_ex_alu_op, id_ex_ctrl, id_ex_valid, id_ex_illegal
   );
endinterface

// File: rtl/id_stage.sv
// id_stage: RV32I decode with register file, load-use stall and ID/EX register.
// Define ID_WB_BYPASS_EN to forward same-cycle write-back data to operand reads.
module id_stage (
   input logic       clk,
   input logic       reset,
   id_stage_if.slave bus
);
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic [3:0]  alu_op;
      logic [8:0]  ctrl;
      logic        valid;
      logic        illegal;
   } idex_t;
   idex_t       ex_q, ex_d, dec;
   logic [31:0] rf_q [32];
   logic [31:0] ins, imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [2:0]  f3;
   logic [3:0]  alu_f;
   logic        hazard;
   assign ins   = bus.if_id_instruction;
   assign f3    = ins[14:12];
   assign imm_i = {{20{ins[31]}}, ins[31:20]};
   assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
   assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
   assign imm_u = {ins[31:12], 12'b0};
   assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
   // funct7[5] selects SUB only for register-register ops; SRA for both forms
   assign alu_f = f3 == 3'd0 ? ((ins[6:0] == 7'h33 && ins[30]) ? 4'd1 : 4'd0) :
                  f3 == 3'd1 ? 4'd2 : f3 == 3'd2 ? 4'd3 : f3 == 3'd3 ? 4'd4 :
                  f3 == 3'd4 ? 4'd5 : f3 == 3'd5 ? (ins[30] ? 4'd7 : 4'd6) :
                  f3 == 3'd6 ? 4'd8 : 4'd9;
   always_comb begin
      dec        = '0;
      dec.pc     = bus.if_id_pc;
      dec.valid  = 1'b1;
      dec.funct3 = f3;
      case (ins[6:0])
         7'h37: begin dec.rd = ins[11:7]; dec.imm = imm_u; dec.alu_op = 4'd10; dec.ctrl = 9'h006; end
         7'h17: begin dec.rd = ins[11:7]; dec.imm = imm_u; dec.ctrl = 9'h007; end
         7'h6F: begin dec.rd = ins[11:7]; dec.imm = imm_j; dec.ctrl = 9'h087; end
         7'h67: begin dec.rd = ins[11:7]; dec.rs1 = ins[19:15]; dec.imm = imm_i; dec.ctrl = 9'h106; end
         7'h63: begin
            dec.rs1 = ins[19:15]; dec.rs2 = ins[24:20]; dec.imm = imm_b;
            dec.alu_op = 4'd1; dec.ctrl = 9'h040;
         end
         7'h03: begin dec.rd = ins[11:7]; dec.rs1 = ins[19:15]; dec.imm = imm_i; dec.ctrl = 9'h02E; end
         7'h23: begin dec.rs1 = ins[19:15]; dec.rs2 = ins[24:20]; dec.imm = imm_s; dec.ctrl = 9'h012; end
         7'h13: begin
            dec.rd = ins[11:7]; dec.rs1 = ins[19:15]; dec.imm = imm_i;
            dec.alu_op = alu_f; dec.ctrl = 9'h006;
         end
         7'h33: begin
            dec.rd = ins[11:7]; dec.rs1 = ins[19:15]; dec.rs2 = ins[24:20];
            dec.alu_op = alu_f; dec.ctrl = 9'h004;
         end
         7'h0F: ;
         default: dec.illegal = 1'b1;
      endcase
      dec.rs1_data = rf_q[dec.rs1];
      dec.rs2_data = rf_q[dec.rs2];
`ifdef ID_WB_BYPASS_EN
      if (bus.wb_we && bus.wb_rd != 5'd0 && bus.wb_rd == dec.rs1) dec.rs1_data = bus.wb_data;
      if (bus.wb_we && bus.wb_rd != 5'd0 && bus.wb_rd == dec.rs2) dec.rs2_data = bus.wb_data;
`endif
   end
   // unused source fields decode to index 0, so they never match a nonzero load rd
   assign hazard    = ex_q.valid && ex_q.ctrl[3] && ex_q.rd != 5'd0 && bus.if_id_valid &&
                      (ex_q.rd == dec.rs1 || ex_q.rd == dec.rs2);
   assign bus.stall = !reset && !bus.flush && (bus.hold || hazard);
   assign ex_d      = bus.flush ? '0 : bus.hold ? ex_q : (hazard || !bus.if_id_valid) ? '0 : dec;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_q <= '0;
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else begin
         ex_q <= ex_d;
         if (bus.wb_we && bus.wb_rd != 5'd0) rf_q[bus.wb_rd] <= bus.wb_data;
      end
   end
   assign bus.id_ex_pc       = ex_q.pc;
   assign bus.id_ex_rs1_data = ex_q.rs1_data;
   assign bus.id_ex_rs2_data = ex_q.rs2_data;
   assign bus.id_ex_imm      = ex_q.imm;
   assign bus.id_ex_rs1      = ex_q.rs1;
   assign bus.id_ex_rs2      = ex_q.rs2;
   assign bus.id_ex_rd       = ex_q.rd;
   assign bus.id_ex_funct3   = ex_q.funct3;
   assign bus.id_ex_alu_op   = ex_q.alu_op;
   assign bus.id_ex_ctrl     = ex_q.ctrl;
   assign bus.id_ex_valid    = ex_q.valid;
   assign bus.id_ex_illegal  = ex_q.illegal;
endmodule
